// File: rtl/bus_read_arbiter_pkg.sv
// Shared types for the bus read arbiter: FSM state encoding and the
// owner encoding used on grant_owner.
package bus_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWNER_DATA  = 1'b0;
  localparam logic OWNER_FETCH = 1'b1;

endpackage

// File: rtl/bus_read_priority.sv
// Winner select between data and fetch requesters: data has fixed priority,
// but fetch is forced through after FETCH_STARVE_LIMIT consecutive data wins.
module bus_read_priority
  import bus_read_arbiter_pkg::*;
#(
  parameter int FETCH_STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic data_valid,
  input  logic fetch_valid,
  input  logic fetch_flush,
  input  logic sample,
  output logic grant,
  output logic owner
);

  localparam int SW = $clog2(FETCH_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_LIMIT = SW'(FETCH_STARVE_LIMIT);

  logic [SW-1:0] streak_q, streak_d;
  logic          fetch_req;
  logic          starved;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fetch_req = fetch_valid & ~fetch_flush;
    starved   = (streak_q == STREAK_LIMIT);
    grant     = data_valid | fetch_req;
    owner     = (fetch_req && (!data_valid || starved)) ? OWNER_FETCH : OWNER_DATA;
    streak_d  = streak_q;
    // The streak only moves when a grant is actually taken from IDLE.
    if (sample && grant) begin
      if (owner == OWNER_FETCH || !fetch_req) begin
        streak_d = '0;
      end else if (!starved) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/bus_read_arbiter.sv
// Shares one bus read port between the data-read and instruction-fetch
// requesters, one outstanding read at a time, with timeout and fetch squash.
module bus_read_arbiter
  import bus_read_arbiter_pkg::*;
#(
  parameter int FETCH_STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_read_valid,
  input  logic [31:0] data_read_address,
  output logic        data_read_ready,
  output logic        data_read_error,
  output logic [31:0] data_read_data,
  input  logic        fetch_read_valid,
  input  logic [31:0] fetch_read_address,
  input  logic        fetch_flush,
  output logic        fetch_read_ready,
  output logic        fetch_read_error,
  output logic [31:0] fetch_read_data,
  output logic        bus_read_valid,
  output logic [31:0] bus_read_address,
  input  logic        bus_read_ready,
  input  logic [31:0] bus_read_data,
  output logic        busy,
  output logic        grant_owner
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        squash_q, squash_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        dr_ready_q, dr_ready_d, dr_err_q, dr_err_d;
  logic [31:0] dr_data_q, dr_data_d;
  logic        fr_ready_q, fr_ready_d, fr_err_q, fr_err_d;
  logic [31:0] fr_data_q, fr_data_d;

  logic        grant, win_owner, finish, squash_now;
  logic [31:0] resp_data;
  logic        resp_err;

  bus_read_priority #(.FETCH_STARVE_LIMIT(FETCH_STARVE_LIMIT)) u_priority (
    .clock       (clock),
    .reset       (reset),
    .data_valid  (data_read_valid),
    .fetch_valid (fetch_read_valid),
    .fetch_flush (fetch_flush),
    .sample      (state_q == ST_IDLE),
    .grant       (grant),
    .owner       (win_owner)
  );

  // Bus ready takes precedence over an expiring timeout in the same cycle.
  assign finish     = (state_q == ST_BUSY) && (bus_read_ready || tmo_q == TIMEOUT_LAST);
  assign squash_now = squash_q | (fetch_flush & (owner_q == OWNER_FETCH));
  assign resp_data  = bus_read_ready ? bus_read_data : 32'h0;
  assign resp_err   = ~bus_read_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      squash_q   <= 1'b0;
      owner_q    <= OWNER_DATA;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      dr_ready_q <= 1'b0;
      dr_err_q   <= 1'b0;
      dr_data_q  <= '0;
      fr_ready_q <= 1'b0;
      fr_err_q   <= 1'b0;
      fr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      squash_q   <= squash_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      dr_ready_q <= dr_ready_d;
      dr_err_q   <= dr_err_d;
      dr_data_q  <= dr_data_d;
      fr_ready_q <= fr_ready_d;
      fr_err_q   <= fr_err_d;
      fr_data_q  <= fr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant) state_d = ST_BUSY;
      ST_BUSY: if (finish) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmo_d      = tmo_q;
    squash_d   = squash_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    busy_d     = (state_d != ST_IDLE);
    dr_ready_d = 1'b0;
    dr_err_d   = 1'b0;
    dr_data_d  = dr_data_q;
    fr_ready_d = 1'b0;
    fr_err_d   = 1'b0;
    fr_data_d  = fr_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          addr_d   = (win_owner == OWNER_FETCH) ? fetch_read_address : data_read_address;
          owner_d  = win_owner;
          valid_d  = 1'b1;
          tmo_d    = '0;
          squash_d = 1'b0;
        end
      end
      ST_BUSY: begin
        tmo_d    = tmo_q + 1'b1;
        squash_d = squash_now;
        if (finish) begin
          valid_d  = 1'b0;
          squash_d = 1'b0;
          if (owner_q == OWNER_DATA) begin
            dr_ready_d = 1'b1;
            dr_err_d   = resp_err;
            dr_data_d  = resp_data;
          end else if (!squash_now) begin
            fr_ready_d = 1'b1;
            fr_err_d   = resp_err;
            fr_data_d  = resp_data;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus_read_valid   = valid_q;
  assign bus_read_address = addr_q;
  assign grant_owner      = owner_q;
  assign busy             = busy_q;
  assign data_read_ready  = dr_ready_q;
  assign data_read_error  = dr_err_q;
  assign data_read_data   = dr_data_q;
  assign fetch_read_ready = fr_ready_q;
  assign fetch_read_error = fr_err_q;
  assign fetch_read_data  = fr_data_q;

endmodule

// File: doc/bus_read_arbiter.md
Name: bus_read_arbiter

Overview:
- Shares the single 32-bit bus read port between two requesters: the data-read port (execute/load path) and the instruction fetch unit.
- Handles one outstanding bus read at a time, with fixed data priority plus an anti-starvation limit for fetch.
- Aborts bus waits that exceed a timeout with an error response.
- Supports a fetch flush (branch redirect) that squashes an in-flight fetch result.

Parameters:
FETCH_STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win (1..15)
TIMEOUT_CYCLES, 255, max cycles in BUSY waiting for bus_read_ready before error response (2..65535)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
data_read_valid  input  1  data requester request, held until data_read_ready
data_read_address  input  32  data read address
data_read_ready  output  1  one-cycle completion pulse to data requester
data_read_error  output  1  qualifies data_read_ready: timeout occurred
data_read_data  output  32  read data, valid with data_read_ready
fetch_read_valid  input  1  fetch request, held until fetch_read_ready
fetch_read_address  input  32  fetch address
fetch_flush  input  1  squash in-flight/pending fetch
fetch_read_ready  output  1  one-cycle completion pulse to fetch
fetch_read_error  output  1  qualifies fetch_read_ready: timeout
fetch_read_data  output  32  read data, valid with fetch_read_ready
bus_read_valid  output  1  bus request, held until bus_read_ready or timeout
bus_read_address  output  32  latched address of granted request
bus_read_ready  input  1  bus completion strobe
bus_read_data  input  32  bus data, valid with bus_read_ready
busy  output  1  high in BUSY and DONE
grant_owner  output  1  0 = data, 1 = fetch; owner of current/last transaction

Behaviour:
- Reset (reset == 0 at an edge): state IDLE. All outputs are 0: bus_read_valid, bus_read_address, the *_ready/_error/_data outputs, busy, grant_owner. Starvation streak, timeout counter and squash flag are cleared. Reset mid-transaction drops bus_read_valid immediately, with no response to either requester.
- All outputs are registered.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Sample requests; fetch_read_valid counts as a request only if fetch_flush == 0.
  - Winner selection: data wins if valid, unless fetch is valid and streak == FETCH_STARVE_LIMIT.
  - On grant: latch the address into bus_read_address, set bus_read_valid = 1, set grant_owner, clear the timeout counter, go to BUSY.
  - Latency: bus_read_valid rises 1 cycle after the request is sampled.
  - Streak: increments (saturating) on a data grant while fetch was also requesting; clears on any fetch grant or when fetch is not requesting at a data grant.
- BUSY:
  - Timeout counter increments each cycle.
  - bus_read_ready == 1: drop bus_read_valid, register bus_read_data to the owner's *_read_data, pulse the owner's *_read_ready for 1 cycle with error = 0, go to DONE.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: drop bus_read_valid, pulse the owner's ready with error = 1 and data = 0, go to DONE.
  - Ready and timeout in the same cycle: ready wins.
  - Requester inputs are ignored in BUSY; a requester dropping valid is a protocol violation, and the response is still issued.
- fetch_flush:
  - While the owner is fetch in BUSY, fetch_flush sets the squash flag.
  - If squashed, completion produces no fetch_read_ready pulse; fetch_read_data is not updated. The bus transaction itself still completes (the bus is not aborted).
  - The squash flag clears on leaving BUSY.
- DONE:
  - Exactly one cycle. The ready pulse is high here; the requester deasserts valid on this edge.
  - Always return to IDLE, which guarantees no re-grant of the completed request.
- Throughput: one bus read per (bus latency + 2) cycles minimum. Back-to-back grants alternate correctly under the streak rule.
- *_read_data holds its last value between pulses; *_read_error is 0 whenever *_read_ready is 0.

Decomposition:
- Shared package: state enum (IDLE, BUSY, DONE) and the owner encoding constants (OWNER_DATA = 0, OWNER_FETCH = 1).
- Counter widths derive locally via $clog2 of the parameters.
- One natural sub-module: bus_read_priority, the combinational winner select plus streak counter (inputs: both valids, flush; outputs: grant, owner). The FSM and datapath stay in the top module.

Test Plan:
- Single data read: data_read_valid = 1, address 0x0000_1000; bus returns 0x1234_5678 8 cycles after bus_read_valid -> bus_read_valid 1 cycle after request, bus_read_address 0x1000, data_read_ready single pulse with data 0x1234_5678, error 0, busy low 2 cycles after bus ready.
- Contention/starvation: both valid continuously, FETCH_STARVE_LIMIT = 4 -> grant sequence D, D, D, D, F, D, D, D, D, F; fetch never waits more than 4 transactions.
- Timeout: fetch read, bus never readies, TIMEOUT_CYCLES = 16 -> bus_read_valid high exactly 16 cycles, then fetch_read_ready pulse with error 1 and data 0, FSM returns to IDLE.
- Flush: fetch granted, fetch_flush pulsed 3 cycles later, bus ready at cycle 8 -> no fetch_read_ready pulse; a new fetch request at 0x0000_0040 is granted after DONE.
- Ready vs timeout coincident: TIMEOUT_CYCLES = 8, bus ready exactly on the 8th BUSY cycle -> normal response, error 0, correct data.
- Reset mid-operation: reset = 0 for one edge during BUSY -> next cycle all outputs 0, state IDLE, no ready pulse; a subsequent request is served normally.
